// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: funct3 encodings,
// load/store FSM states and the default word-index width.
package mem_pkg;

  localparam int MEM_IDX_W_DFLT = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

endpackage

// File: rtl/load_extend.sv
// Lane select plus sign/zero extension of a 32-bit memory word for RV32I loads.
// Combinational, zero latency; no flow control (shared with the forwarding path).
// Word loads pass straight through.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit mapping RV32I byte/half/word accesses onto a word-only data memory.
// Loads: 1-cycle registered result. SW: single cycle. SB/SH: 2-cycle read-modify-write.
// Backpressure: stall is raised for the read cycle of an SB/SH; nothing else stalls.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_IDX_W = MEM_IDX_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              misalign,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              mem_we,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  state_t                 state_q, state_d;
  logic [31:0]            merge_q;
  logic [MEM_IDX_W-1:0]   idx_q;
  logic [MEM_IDX_W-1:0]   req_idx;
  logic [1:0]             off;
  logic                   aligned, legal, accept;
  logic                   is_load, is_sw, is_rmw, bad;
  logic [31:0]            merged;
  logic [31:0]            ext_data;
  logic                   unused_addr;

  assign req_idx     = req_addr[MEM_IDX_W+1:2];
  assign off         = req_addr[1:0];
  // Upper address bits wrap onto the 1024-word memory.
  assign unused_addr = ^req_addr[ADDR_W-1:MEM_IDX_W+2];

  always_comb begin
    case (req_funct3)
      F3_B, F3_BU: aligned = 1'b1;
      F3_H, F3_HU: aligned = ~off[0];
      F3_W:        aligned = (off == 2'b00);
      default:     aligned = 1'b0;
    endcase
    // Stores only have B/H/W forms; the unsigned encodings are illegal for them.
    legal   = aligned && (!req_we || req_funct3 == F3_B || req_funct3 == F3_H ||
                          req_funct3 == F3_W);
    accept  = (state_q == IDLE) && req_valid;
    is_load = accept && !req_we && legal;
    is_sw   = accept && req_we && legal && (req_funct3 == F3_W);
    is_rmw  = accept && req_we && legal && (req_funct3 != F3_W);
    bad     = accept && !legal;
  end

  always_comb begin
    merged = mem_rd;
    if (req_funct3 == F3_B) merged[{off, 3'b000} +: 8] = req_wdata[7:0];
    else                    merged[{off[1], 4'b0000} +: 16] = req_wdata[15:0];
  end

  load_extend u_load_extend (
    .word   (mem_rd),
    .offset (off),
    .funct3 (req_funct3),
    .data   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mem_we  = 1'b0;
    mem_a   = {{(32-MEM_IDX_W){1'b0}}, req_idx};
    mem_wd  = req_wdata;
    case (state_q)
      IDLE: begin
        stall  = is_rmw;
        mem_we = is_sw;
        if (is_rmw) state_d = RMW_WR;
      end
      RMW_WR: begin
        mem_we  = 1'b1;
        mem_a   = {{(32-MEM_IDX_W){1'b0}}, idx_q};
        mem_wd  = merge_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      misalign <= 1'b0;
      ld_valid <= 1'b0;
      ld_data  <= 32'h0;
      merge_q  <= 32'h0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      misalign <= bad;
      ld_valid <= is_load;
      if (is_load) ld_data <= ext_data;
      if (is_rmw) begin
        merge_q <= merged;
        idx_q   <= req_idx;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the execute/memory pipeline register and the word-addressed data memory of the 5-stage RISC-V core.
- Converts RV32I byte/half/word loads and stores into 32-bit word accesses.
- Sign- or zero-extends load data and registers it for the writeback stage.
- Performs sub-word stores as a 2-cycle read-modify-write, stalling the pipeline for one cycle, because the data memory only supports full-word writes.

Parameters:
- ADDR_W, 32, byte-address width from the pipeline.
- MEM_IDX_W, 10, word-index width driven to the data memory (1024 words).

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  memory-stage instruction is a load or store
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  32  store data (rs2), right-aligned
- stall  out  1  freeze IF/ID/EX and the EX/MEM register this cycle
- misalign  out  1  registered flag: previous accepted request was misaligned (dropped)
- ld_data  out  32  registered extended load result for MEM/WB
- ld_valid  out  1  registered: ld_data holds a new load result
- mem_we  out  1  to data memory WE
- mem_a  out  32  to data memory A: zero-extended word index req_addr[MEM_IDX_W+1:2]
- mem_wd  out  32  to data memory WD
- mem_rd  in  32  from data memory RD (combinational read)

Behaviour:
- Reset (rst=0, async): state=IDLE; stall, misalign, ld_valid, mem_we = 0; ld_data = 0; merge register = 0.
- States: IDLE, RMW_WR.
- Alignment: H/HU require addr[0]=0; W requires addr[1:0]=00.
  - Misaligned request: no memory write, ld_valid=0 next cycle, misalign=1 for exactly one cycle.
  - Funct3 011/110/111 are treated as misaligned.
- Load (IDLE, req_valid, !req_we, aligned):
  - mem_a = word index; lane selected by addr[1:0].
  - B/BU extract byte addr[1:0]*8; H/HU extract half addr[1]*16.
  - B/H sign-extend; BU/HU zero-extend.
  - Registered into ld_data with ld_valid=1 on the next edge. Latency 1, no stall.
- SW (IDLE, aligned): mem_we=1, mem_wd=req_wdata in the same cycle. No stall. Stays IDLE.
- SB/SH (IDLE, aligned), cycle 0:
  - Read mem_rd; replace the target lane with req_wdata[7:0] or [15:0]; latch the merged word and word index.
  - stall=1, mem_we=0. Next state RMW_WR.
- RMW_WR, cycle 1:
  - mem_a = latched index, mem_wd = latched merged word, mem_we=1, stall=0.
  - req inputs are ignored this cycle; the pipeline was frozen, so they are unchanged.
  - Next state IDLE; the following cycle accepts a new request.
- stall is combinational from state and inputs: high only in IDLE with an aligned SB/SH.
- ld_valid clears on any cycle without an accepted aligned load. ld_data holds its last value.
- mem_a is driven from req_addr in IDLE even when req_valid=0; mem_we=0 in that case.
- Address bits above MEM_IDX_W+1 are ignored (wrap).
- Reset asserted mid-RMW: return to IDLE immediately; the pending write is discarded and memory is unchanged.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum {IDLE, RMW_WR}
  - MEM_IDX_W default
- One natural sub-module: load_extend, a pure combinational lane select plus sign/zero extend (word, addr[1:0], funct3 -> 32-bit). It is reused by the forwarding logic.

Test Plan:
- mem word 1 = 0x80F0_1234. LB addr 0x4 -> ld_data=0x0000_0034; LB addr 0x7 -> 0xFFFF_FF80; LBU addr 0x7 -> 0x0000_0080; LH addr 0x6 -> 0xFFFF_80F0. ld_valid=1 one cycle after each; stall never asserted.
- SW 0xDEAD_BEEF to addr 0x8 -> mem_we=1 same cycle, mem_a=2. A following LW addr 0x8 -> ld_data=0xDEAD_BEEF.
- Word 2 = 0xDEAD_BEEF. SB 0x55 to addr 0x9:
  - cycle 0: stall=1, mem_we=0
  - cycle 1: mem_we=1, mem_wd=0xDEAD_55EF, stall=0
  - LW addr 0x8 afterwards -> 0xDEAD_55EF.
- SH 0x1234 to addr 0xA -> word 2 becomes 0x1234_55EF. SH to addr 0xB -> misalign=1 one cycle, memory unchanged, no stall.
- SB issued, then rst pulled low during RMW_WR -> state IDLE, mem_we=0 immediately, word unchanged after reset release.
- Back-to-back SB addr 0x4 then LB addr 0x4: the load is presented only after the RMW completes and returns the newly written byte.
